ibra_valrdy_to_credit: RTL and testbench

Converts a valid/ready (val/rdy) flit stream into a credit-based stream. It is the transmit-side counterpart of `ibra_credit_to_valrdy`. The block sits between a val/rdy producer (core-side or bridge logic) and a credit-based link whose receiver returns one `yummy` pulse per freed buffer slot. A small input FIFO decouples acceptance from transmission, and a credit counter ensures the downstream buffer is never overrun.

---
 rtl/ibra_valrdy_to_credit.sv | 107 ++++++++++
 tb/tb_ibra_valrdy_to_credit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ibra_valrdy_to_credit.sv
// Valid/ready to credit-based link converter: a small input FIFO feeds a
// registered one-cycle-pulse transmitter gated by a downstream credit counter.
module ibra_valrdy_to_credit #(
    parameter int DATA_WIDTH = 64,
    parameter int CREDITS    = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  yummy_in,
    output logic                  credit_err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W = $clog2(CREDITS + 1);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [OCC_W-1:0]      r_occ;
    logic [CNT_W-1:0]      r_credit_cnt;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_valid_out;
    logic                  r_credit_err;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_send;

    always_comb begin
        w_full  = (r_occ == OCC_W'(FIFO_DEPTH));
        w_empty = (r_occ == '0);
        w_push  = valid_in && !w_full;
        w_send  = !w_empty && (r_credit_cnt != '0);
    end

    assign ready_in   = !w_full;
    assign data_out   = r_data_out;
    assign valid_out  = r_valid_out;
    assign credit_err = r_credit_err;

    // Storage is not reset: occupancy alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_send) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_send) begin
                r_occ <= r_occ + OCC_W'(1);
            end else if (w_send && !w_push) begin
                r_occ <= r_occ - OCC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_valid_out <= w_send;
            if (w_send) begin
                r_data_out <= r_mem[r_rd_ptr];
            end
        end
    end

    // A returned credit with the counter already full is a receiver protocol error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_credit_cnt <= CNT_W'(CREDITS);
            r_credit_err <= 1'b0;
        end else begin
            case ({w_send, yummy_in})
                2'b10: r_credit_cnt <= r_credit_cnt - CNT_W'(1);
                2'b01: begin
                    if (r_credit_cnt == CNT_W'(CREDITS)) begin
                        r_credit_err <= 1'b1;
                    end else begin
                        r_credit_cnt <= r_credit_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ibra_valrdy_to_credit.sv
// Directed self-checking bench for ibra_valrdy_to_credit (CREDITS=3, FIFO_DEPTH=2).
module tb_ibra_valrdy_to_credit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] data_in = '0;
    logic        valid_in = 1'b0;
    logic        ready_in;
    logic [63:0] data_out;
    logic        valid_out;
    logic        yummy_in = 1'b0;
    logic        credit_err;

    int checks = 0;
    int errors = 0;

    ibra_valrdy_to_credit #(
        .DATA_WIDTH(64),
        .CREDITS   (3),
        .FIFO_DEPTH(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .yummy_in  (yummy_in),
        .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs then reflect that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid_in = 1'b0;
        yummy_in = 1'b0;
        reset    = 1'b1;
        tick();
        tick();
        reset    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            data_in  = {$urandom, $urandom};
            valid_in = 1'($urandom_range(0, 1));
            yummy_in = 1'($urandom_range(0, 1));
            tick();
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_async_valid: got %b expected 0", valid_out); end
        checks++;
        if (data_out !== 64'h0) begin errors++; $display("FAIL reset_async_data: got %h expected 0", data_out); end
        checks++;
        if (credit_err !== 1'b0) begin errors++; $display("FAIL reset_async_err: got %b expected 0", credit_err); end
        tick();
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_held_valid: got %b expected 0", valid_out); end
        reset    = 1'b0;
        valid_in = 1'b0;
        yummy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ready_in !== 1'b1) begin errors++; $display("FAIL reset_ready[%0d]: got %b expected 1", i, ready_in); end
            checks++;
            if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_idle_valid[%0d]: got %b expected 0", i, valid_out); end
        end
        checks++;
        if (dut.r_credit_cnt !== 2'd3) begin errors++; $display("FAIL reset_credit: got %0d expected 3", dut.r_credit_cnt); end
    endtask

    task automatic test_packet();
        logic [63:0] pkt [3];
        pkt[0] = 64'h800000008084c008;
        pkt[1] = 64'h00fff10100000300;
        pkt[2] = 64'h0;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            valid_in = (k < 3);
            data_in  = (k < 3) ? pkt[k] : 64'hdead_beef_dead_beef;
            tick();
            checks++;
            if (valid_out !== (k >= 1 && k <= 3)) begin
                errors++;
                $display("FAIL packet_valid[%0d]: got %b expected %b", k, valid_out, (k >= 1 && k <= 3));
            end
            if (k >= 1 && k <= 3) begin
                checks++;
                if (data_out !== pkt[k-1]) begin errors++; $display("FAIL packet_data[%0d]: got %h expected %h", k, data_out, pkt[k-1]); end
            end
        end
        checks++;
        if (dut.r_credit_cnt !== 2'd0) begin errors++; $display("FAIL packet_credit: got %0d expected 0", dut.r_credit_cnt); end
    endtask

    task automatic test_exhaustion();
        logic [63:0] d [5];
        logic        exp_vo  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        exp_rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) d[i] = 64'hD000_0000_0000_0000 + 64'(i);
        do_reset();
        for (int k = 0; k < 6; k++) begin
            valid_in = (k < 5);
            data_in  = (k < 5) ? d[k] : '0;
            tick();
            checks++;
            if (valid_out !== exp_vo[k]) begin errors++; $display("FAIL exh_valid[%0d]: got %b expected %b", k, valid_out, exp_vo[k]); end
            checks++;
            if (ready_in !== exp_rdy[k]) begin errors++; $display("FAIL exh_ready[%0d]: got %b expected %b", k, ready_in, exp_rdy[k]); end
            if (exp_vo[k]) begin
                checks++;
                if (data_out !== d[k-1]) begin errors++; $display("FAIL exh_data[%0d]: got %h expected %h", k, data_out, d[k-1]); end
            end
        end
        valid_in = 1'b0;
        for (int y = 0; y < 2; y++) begin
            yummy_in = 1'b1;
            tick();
            yummy_in = 1'b0;
            checks++;
            if (valid_out !== 1'b0) begin errors++; $display("FAIL exh_yummy_nosend[%0d]: got %b expected 0", y, valid_out); end
            tick();
            checks++;
            if (valid_out !== 1'b1) begin errors++; $display("FAIL exh_resume_valid[%0d]: got %b expected 1", y, valid_out); end
            checks++;
            if (data_out !== d[3+y]) begin errors++; $display("FAIL exh_resume_data[%0d]: got %h expected %h", y, data_out, d[3+y]); end
            checks++;
            if (ready_in !== 1'b1) begin errors++; $display("FAIL exh_resume_ready[%0d]: got %b expected 1", y, ready_in); end
        end
        tick();
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL exh_drained: got %b expected 0", valid_out); end
        checks++;
        if (dut.r_credit_cnt !== 2'd0) begin errors++; $display("FAIL exh_credit: got %0d expected 0", dut.r_credit_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] f [10];
        for (int i = 0; i < 10; i++) f[i] = 64'h1000_0000_0000_0000 + 64'(i) * 64'h0101;
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            valid_in = (k <= 10);
            data_in  = (k <= 10) ? f[k-1] : '0;
            yummy_in = (k >= 3 && k <= 11);
            tick();
            if (k >= 2 && k <= 11) begin
                checks++;
                if (valid_out !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected 1", k, valid_out); end
                checks++;
                if (data_out !== f[k-2]) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", k, data_out, f[k-2]); end
                checks++;
                if (dut.r_credit_cnt < 2'd1) begin errors++; $display("FAIL b2b_credit_floor[%0d]: got %0d expected >=1", k, dut.r_credit_cnt); end
            end
        end
        yummy_in = 1'b0;
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL b2b_end_valid: got %b expected 0", valid_out); end
        checks++;
        if (dut.r_credit_cnt !== 2'd2) begin errors++; $display("FAIL b2b_end_credit: got %0d expected 2", dut.r_credit_cnt); end
        checks++;
        if (credit_err !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b expected 0", credit_err); end
    endtask

    task automatic test_overflow();
        do_reset();
        tick();
        checks++;
        if (credit_err !== 1'b0) begin errors++; $display("FAIL ovf_pre_err: got %b expected 0", credit_err); end
        yummy_in = 1'b1;
        tick();
        yummy_in = 1'b0;
        checks++;
        if (credit_err !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b expected 1", credit_err); end
        checks++;
        if (dut.r_credit_cnt !== 2'd3) begin errors++; $display("FAIL ovf_credit: got %0d expected 3", dut.r_credit_cnt); end
        repeat (3) tick();
        checks++;
        if (credit_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", credit_err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        valid_in = 1'b1;
        data_in  = 64'hAAAA_0000_0000_0001;
        tick();
        data_in  = 64'hAAAA_0000_0000_0002;
        tick();
        checks++;
        if (valid_out !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b expected 1", valid_out); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL mid_async_valid: got %b expected 0", valid_out); end
        valid_in = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (valid_out !== 1'b0) begin errors++; $display("FAIL mid_stale[%0d]: got %b expected 0", i, valid_out); end
        end
        checks++;
        if (dut.r_credit_cnt !== 2'd3) begin errors++; $display("FAIL mid_credit: got %0d expected 3", dut.r_credit_cnt); end
        checks++;
        if (ready_in !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", ready_in); end
    endtask

    initial begin
        test_reset();
        test_packet();
        test_exhaustion();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
